// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, branch-redirect and decode handshake bundle of the fetch stage.
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               br_take;
    logic [ADDR_W-1:0]  br_base;
    logic [ADDR_W-1:0]  br_offset;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic               id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, br_take, br_base, br_offset, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, br_take, br_base, br_offset, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches one word at a time and hands it to decode; branches redirect and kill in-flight fetches.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    // bit 0 of the encoding is the memory request itself
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_REQ = 2'b01, S_KILL = 2'b11} state_t;

    state_t             r_state, w_state;
    logic [ADDR_W-1:0]  r_pc, w_pc, r_req_addr, w_req_addr, r_if_pc, w_if_pc, w_target;
    logic [INSTR_W-1:0] r_instr, w_instr;
    logic               r_valid, w_valid;

    assign w_target = bus.br_base + bus.br_offset;

    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_req_addr = r_req_addr;
        w_valid    = r_valid;
        w_instr    = r_instr;
        w_if_pc    = r_if_pc;
        if (bus.br_take) begin
            w_pc    = w_target;
            w_valid = 1'b0;
            if (r_state == S_IDLE || bus.imem_ack) begin
                w_state    = S_REQ;
                w_req_addr = w_target;
            end else begin
                w_state = S_KILL;
            end
        end else begin
            case (r_state)
                S_IDLE: if (!r_valid || bus.id_ready) begin
                    w_valid    = 1'b0;
                    w_req_addr = r_pc;
                    w_state    = S_REQ;
                end
                S_REQ: if (bus.imem_ack) begin
                    w_instr = bus.imem_rdata;
                    w_if_pc = r_req_addr;
                    w_valid = 1'b1;
                    w_pc    = r_req_addr + ADDR_W'(1);
                    w_state = S_IDLE;
                end
                S_KILL: if (bus.imem_ack) begin
                    w_req_addr = r_pc;
                    w_state    = S_REQ;
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_if_pc    <= '0;
        end else begin
            r_state    <= w_state;
            r_pc       <= w_pc;
            r_req_addr <= w_req_addr;
            r_valid    <= w_valid;
            r_instr    <= w_instr;
            r_if_pc    <= w_if_pc;
        end
    end

    assign bus.imem_req  = r_state[0];
    assign bus.imem_addr = r_req_addr;
    assign bus.if_valid  = r_valid;
    assign bus.if_instr  = r_instr;
    assign bus.if_pc     = r_if_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a pending/stale fetch model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus();
    fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a fetch is either absent or pending; a pending fetch may be stale (killed by a branch).
    logic [15:0] m_pc, m_addr, m_instr, m_ifpc;
    bit          m_pend, m_stale, m_valid;

    always @(posedge clk) begin : model
        logic [15:0] pc, addr, instr, ifpc;
        bit pend, stale, valid;
        pc = m_pc; addr = m_addr; instr = m_instr; ifpc = m_ifpc;
        pend = m_pend; stale = m_stale; valid = m_valid;
        if (rst) begin
            pc = 16'h0000; addr = 16'h0000; instr = 16'h0000; ifpc = 16'h0000;
            pend = 0; stale = 0; valid = 0;
        end else if (bus.br_take) begin
            valid = 0;
            pc = bus.br_base + bus.br_offset;
            if (!pend) begin
                pend = 1; addr = pc;
            end else if (bus.imem_ack) begin
                addr = pc; stale = 0;
            end else begin
                stale = 1;
            end
        end else if (!pend) begin
            if (!valid || bus.id_ready) begin
                valid = 0; pend = 1; addr = pc;
            end
        end else if (bus.imem_ack) begin
            if (stale) begin
                stale = 0; addr = pc;
            end else begin
                valid = 1; instr = bus.imem_rdata; ifpc = addr; pc = addr + 16'd1; pend = 0;
            end
        end
        m_pc <= pc; m_addr <= addr; m_instr <= instr; m_ifpc <= ifpc;
        m_pend <= pend; m_stale <= stale; m_valid <= valid;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("imem_req", 32'(bus.imem_req), 32'(m_pend));
            chk("imem_addr", 32'(bus.imem_addr), 32'(m_addr));
            chk("if_valid", 32'(bus.if_valid), 32'(m_valid));
            chk("if_instr", 32'(bus.if_instr), 32'(m_instr));
            chk("if_pc", 32'(bus.if_pc), 32'(m_ifpc));
        end
    end

    task automatic step(input bit ack);
        @(negedge clk);
        bus.imem_ack   = ack;
        bus.imem_rdata = 16'hA000 + bus.imem_addr;
    endtask

    initial begin
        int n, last;
        logic [15:0] hold_pc, hold_instr;
        bus.imem_ack = 0; bus.imem_rdata = 0; bus.br_take = 0;
        bus.br_base = 0; bus.br_offset = 0; bus.id_ready = 0;
        // T1 reset
        step(0); cmp_en = 1'b1;
        step(0); step(0);
        rst = 1'b0;
        chk("t1_valid", 32'(bus.if_valid), 32'd0);
        chk("t1_req_c1", 32'(bus.imem_req), 32'd0);
        step(0);
        chk("t1_req_c2", 32'(bus.imem_req), 32'd1);
        chk("t1_addr", 32'(bus.imem_addr), 32'h0000);
        // T2 stream
        bus.id_ready = 1;
        n = 0; last = -1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.if_valid && n < 4) begin
                chk("t2_pc", 32'(bus.if_pc), 32'(n));
                chk("t2_instr", 32'(bus.if_instr), 32'h0000A000 + 32'(n));
                if (last >= 0) chk("t2_gap", 32'(i - last), 32'd2);
                last = i; n++;
            end
        end
        chk("t2_count", 32'(n), 32'd4);
        // T3 backpressure
        bus.id_ready = 0;
        for (int k = 0; k < 4 && !bus.if_valid; k++) step(1);
        hold_pc = bus.if_pc; hold_instr = bus.if_instr;
        for (int k = 0; k < 5; k++) begin
            step(0);
            chk("t3_valid", 32'(bus.if_valid), 32'd1);
            chk("t3_pc", 32'(bus.if_pc), 32'(hold_pc));
            chk("t3_instr", 32'(bus.if_instr), 32'(hold_instr));
            chk("t3_req", 32'(bus.imem_req), 32'd0);
        end
        bus.id_ready = 1;
        step(1);
        chk("t3_next_addr", 32'(bus.imem_addr), 32'(hold_pc + 16'd1));
        step(1);
        chk("t3_next_pc", 32'(bus.if_pc), 32'(hold_pc + 16'd1));
        // T4 branch in idle drops the held instruction
        bus.id_ready = 0;
        step(0);
        chk("t4_held", 32'(bus.if_valid), 32'd1);
        bus.br_take = 1; bus.br_base = 16'h0010; bus.br_offset = 16'hFFF8;
        step(0);
        bus.br_take = 0;
        chk("t4_req", 32'(bus.imem_req), 32'd1);
        chk("t4_addr", 32'(bus.imem_addr), 32'h0008);
        chk("t4_drop", 32'(bus.if_valid), 32'd0);
        // T5 kill with delayed ack
        bus.br_take = 1; bus.br_base = 16'h0004; bus.br_offset = 16'h000C;
        step(0);
        bus.br_take = 0;
        for (int k = 0; k < 2; k++) begin
            chk("t5_stale_addr", 32'(bus.imem_addr), 32'h0008);
            chk("t5_stale_req", 32'(bus.imem_req), 32'd1);
            step(0);
        end
        chk("t5_stale_addr", 32'(bus.imem_addr), 32'h0008);
        step(1);
        step(0);
        chk("t5_no_valid", 32'(bus.if_valid), 32'd0);
        chk("t5_new_addr", 32'(bus.imem_addr), 32'h0010);
        step(1);
        step(0);
        chk("t5_pc", 32'(bus.if_pc), 32'h0010);
        chk("t5_instr", 32'(bus.if_instr), 32'hA010);
        // T6 wrap, then reset mid-fetch
        bus.br_take = 1; bus.br_base = 16'hFFFF; bus.br_offset = 16'h0000;
        step(0);
        bus.br_take = 0;
        step(1);
        step(0);
        chk("t6_pc", 32'(bus.if_pc), 32'hFFFF);
        chk("t6_instr", 32'(bus.if_instr), 32'h9FFF);
        bus.id_ready = 1;
        step(0);
        chk("t6_wrap_addr", 32'(bus.imem_addr), 32'h0000);
        chk("t6_wrap_req", 32'(bus.imem_req), 32'd1);
        rst = 1;
        step(1);
        chk("t6_rst_req", 32'(bus.imem_req), 32'd0);
        step(1);
        rst = 0;
        step(1);
        chk("t6_late_ack", 32'(bus.if_valid), 32'd0);
        chk("t6_refetch", 32'(bus.imem_addr), 32'h0000);
        chk("t6_refetch_req", 32'(bus.imem_req), 32'd1);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 1)));
            bus.id_ready  = ($urandom_range(0, 3) != 0);
            bus.br_take   = ($urandom_range(0, 7) == 0);
            bus.br_base   = 16'($urandom);
            bus.br_offset = 16'($urandom);
            rst           = ($urandom_range(0, 199) == 0);
        end
        rst = 0; bus.br_take = 0;
        step(0);
        step(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
